pipeline_preload_ctrl: RTL and testbench
========================================

// Module: pipeline_preload_ctrl
// PURPOSE
// - Sequencer for a fixed-latency set-able shift pipeline (no stall input; advances every clk).
// - Feeds pipe_in from a ready/valid stream, tracks per-stage valid bits, and runs a
//   drain -> collect -> commit sequence that preloads all stages at once via set/set_data.
// - Sits between the upstream producer and the pipeline instance; downstream sees out_data/out_valid.
// PARAMETERS
// - BIT_WIDTH         10  width of one stage word
// - NUMBER_OF_STAGES  5   pipeline depth N; legal range 1..32
// PORTS
// - clk         in   1      clock; all state updates on posedge clk
// - reset_n     in   1      synchronous, active-low reset
// - in_valid    in   1      upstream word valid
// - in_data     in   BW     upstream word
// - in_ready    out  1      word accepted when in_valid & in_ready
// - load_start  in   1      request preload sequence (sampled in RUN only)
// - load_valid  in   1      preload word valid
// - load_data   in   BW     preload word, k-th accepted word -> stage k (0 = first stage)
// - load_ready  out  1      preload word accepted when load_valid & load_ready
// - flush       in   1      sync clear of all valid bits; aborts any sequence
// - pipe_in     out  BW     to pipeline input
// - set         out  1      to pipeline set (one-cycle pulse)
// - set_data    out  BW*N   to pipeline set_data; slice k = stage k
// - pipe_out    in   BW     from pipeline output
// - out_data    out  BW     = pipe_out (pass-through)
// - out_valid   out  1      = vld[N-1]
// - busy        out  1      state != RUN
// BEHAVIOUR
// - States: RUN, DRAIN, LOAD, COMMIT. Reset (reset_n=0 at clk edge): state=RUN, vld=0,
//   cnt=0, buffer=0; outputs: in_ready=1, load_ready=0, set=0, pipe_in=0, out_valid=0, busy=0.
// - vld[N-1:0] shift register mirrors the pipeline: every cycle vld <= {vld[N-2:0], acc},
//   acc = in_valid & in_ready. Latency: word accepted at edge t is on pipe_out after edge t+N-1,
//   i.e. out_valid for exactly one cycle N clocks after acceptance.
// - RUN: in_ready = !load_start & !flush; pipe_in = acc ? in_data : 0.
//   load_start=1 -> DRAIN (load_start beats same-cycle in_valid; word not accepted).
// - DRAIN: in_ready=0, pipe_in=0, bubbles shift; in-flight words still emerge with out_valid.
//   When vld==0 (sampled this cycle) -> LOAD next cycle, cnt=0.
// - LOAD: load_ready=1, in_ready=0; each handshake writes buffer[cnt], cnt++;
//   handshake with cnt==N-1 -> COMMIT. Gaps in load_valid allowed, no timeout.
// - COMMIT (exactly one cycle): set=1, set_data=buffer, in_ready=0, load_ready=0;
//   vld <= all ones; -> RUN. Preloaded words then exit order stage N-1 first, stage 0 last.
// - set_data is driven from buffer in all states; set=0 outside COMMIT.
// - flush=1 (any state): vld <= 0, cnt <= 0, state <= RUN, set=0 that cycle, in_ready=0;
//   flush during COMMIT suppresses set. Partial buffer contents are retained but unused.
// - reset_n=0 mid-sequence: same end state as reset; no set pulse.
// - load_start outside RUN ignored. N=1: DRAIN lasts <=1 cycle, LOAD takes one word.
// - cnt width = clog2(N) (min 1); no arithmetic overflow possible since cnt < N.
// STRUCTURE
// - Shared package pipe_ctrl_pkg: state encoding localparams (RUN/DRAIN/LOAD/COMMIT, 2 bits).
// - One sub-module natural: pipe_load_buffer (N x BW word-indexed write register,
//   flat BW*N read port, sync active-low clear); FSM + vld tracker stay in top.
// - Pipeline itself instantiated by the parent, not inside this block.
// TESTING
// - Stream: N=5, in_data 1..8 back-to-back -> out_data 1..8 with out_valid, first 5 clocks
//   after acceptance, no gaps, no extra valids.
// - Preload from idle: load_start, then words A0..A4 -> set pulses once, next 5 cycles
//   out_data=A4,A3,A2,A1,A0 with out_valid=1, then out_valid=0.
// - Preload with 3 words in flight: DRAIN holds in_ready=0 until all 3 emerge, LOAD entered
//   next cycle; load_valid with 2-cycle gaps still yields single set after 5th word.
// - load_start and in_valid same cycle in RUN -> word not accepted, busy=1 next cycle.
// - flush in LOAD after 2 words -> RUN next cycle, no set, out_valid stays 0; new load_start
//   restarts at cnt=0.
// - reset_n low during COMMIT cycle -> set not seen by pipeline update, all outputs at reset values.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the preload sequencer: FSM state encoding and counter sizing.
package pipe_ctrl_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
  localparam logic [ST_W-1:0] ST_DRAIN  = 2'd1;
  localparam logic [ST_W-1:0] ST_LOAD   = 2'd2;
  localparam logic [ST_W-1:0] ST_COMMIT = 2'd3;

  typedef enum logic [ST_W-1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    LOAD   = ST_LOAD,
    COMMIT = ST_COMMIT
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_preload_ctrl_if.sv
// Upstream-side bundle: streaming input, preload word stream, and control requests.
interface pipeline_preload_ctrl_if #(
  parameter int BIT_WIDTH = 10
);
  logic                 in_valid;
  logic [BIT_WIDTH-1:0] in_data;
  logic                 in_ready;
  logic                 load_start;
  logic                 load_valid;
  logic [BIT_WIDTH-1:0] load_data;
  logic                 load_ready;
  logic                 flush;

  modport master (
    output in_valid, in_data, load_start, load_valid, load_data, flush,
    input  in_ready, load_ready
  );

  modport slave (
    input  in_valid, in_data, load_start, load_valid, load_data, flush,
    output in_ready, load_ready
  );
endinterface

// File: rtl/pipe_load_buffer.sv
// Word-indexed staging register for preload words; read back flat, slice k = stage k.
module pipe_load_buffer #(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5,
  parameter int ADDR_W           = 3
) (
  input  logic                                  clk,
  input  logic                                  clr_n,
  input  logic                                  we_i,
  input  logic [ADDR_W-1:0]                     waddr_i,
  input  logic [BIT_WIDTH-1:0]                  wdata_i,
  output logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0] rdata_o
);

  logic [NUMBER_OF_STAGES-1:0][BIT_WIDTH-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      buf_q <= '0;
    end else if (we_i) begin
      buf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = buf_q;

endmodule

// File: rtl/pipeline_preload_ctrl.sv
// Sequencer for a fixed-latency set-able shift pipeline: streams words in, tracks
// per-stage valids, and runs drain -> collect -> commit to preload every stage at once.
module pipeline_preload_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH        = 10,
  parameter int NUMBER_OF_STAGES = 5
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  pipeline_preload_ctrl_if.slave                up,
  output logic [BIT_WIDTH-1:0]                  pipe_in,
  output logic                                  set,
  output logic [BIT_WIDTH*NUMBER_OF_STAGES-1:0] set_data,
  input  logic [BIT_WIDTH-1:0]                  pipe_out,
  output logic [BIT_WIDTH-1:0]                  out_data,
  output logic                                  out_valid,
  output logic                                  busy
);

  localparam int N = NUMBER_OF_STAGES;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     vld_q, vld_d;
  logic             in_ready, load_ready, acc, load_hs;

  always_comb begin
    in_ready   = (state_q == RUN) && !up.load_start && !up.flush;
    load_ready = (state_q == LOAD) && !up.flush;
    acc        = up.in_valid && in_ready;
    load_hs    = up.load_valid && load_ready;
    pipe_in    = acc ? up.in_data : '0;
    // Gating with reset_n keeps the pipeline from loading when reset hits the commit cycle.
    set        = (state_q == COMMIT) && !up.flush && reset_n;

    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = (vld_q << 1) | N'(acc);

    case (state_q)
      RUN: begin
        if (up.load_start) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_q == '0) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (load_hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        vld_d   = '1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (up.flush) begin
      vld_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  pipe_load_buffer #(
    .BIT_WIDTH       (BIT_WIDTH),
    .NUMBER_OF_STAGES(N),
    .ADDR_W          (CNT_W)
  ) u_buf (
    .clk    (clk),
    .clr_n  (reset_n),
    .we_i   (load_hs),
    .waddr_i(cnt_q),
    .wdata_i(up.load_data),
    .rdata_o(set_data)
  );

  assign up.in_ready   = in_ready;
  assign up.load_ready = load_ready;
  assign out_data      = pipe_out;
  assign out_valid     = vld_q[N-1];
  assign busy          = (state_q != RUN);

endmodule

// File: tb/tb_pipeline_preload_ctrl.sv
// Directed bench for pipeline_preload_ctrl with a behavioural set-able shift pipeline (N=5, BW=10).
module tb_pipeline_preload_ctrl;

  localparam int BW = 10;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BW-1:0] pipe_in, pipe_out, out_data;
  logic          set, out_valid, busy;
  logic [BW*N-1:0] set_data;
  logic [BW*N-1:0] stg = '0;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0]   wa [N];
  logic [BW*N-1:0] exp_sd;

  pipeline_preload_ctrl_if #(.BIT_WIDTH(BW)) bus ();

  pipeline_preload_ctrl #(
    .BIT_WIDTH       (BW),
    .NUMBER_OF_STAGES(N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .up       (bus.slave),
    .pipe_in  (pipe_in),
    .set      (set),
    .set_data (set_data),
    .pipe_out (pipe_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // The pipeline the sequencer drives: stage 0 takes pipe_in, stage N-1 is the output.
  always_ff @(posedge clk) begin
    if (set) stg <= set_data;
    else     stg <= {stg[BW*(N-1)-1:0], pipe_in};
  end
  assign pipe_out = stg[BW*N-1 -: BW];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_words(input int base, input int step);
    for (int k = 0; k < N; k++) begin
      wa[k] = BW'(base + k * step);
      exp_sd[k*BW +: BW] = wa[k];
    end
  endtask

  task automatic enter_load();
    tick(); bus.load_start = 1'b1; #1;
    tick(); bus.load_start = 1'b0; #1;
    tick(); #1;
    chk("enter_load_ready", 64'(bus.load_ready), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.flush      = 1'b0;
    exp_sd         = '0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_in_ready",   64'(bus.in_ready),   64'(1));
    chk("rst_load_ready", 64'(bus.load_ready), 64'(0));
    chk("rst_set",        64'(set),            64'(0));
    chk("rst_pipe_in",    64'(pipe_in),        64'(0));
    chk("rst_out_valid",  64'(out_valid),      64'(0));
    chk("rst_busy",       64'(busy),           64'(0));
    chk("rst_set_data",   64'(set_data),       64'(0));
    reset_n = 1'b1;

    // Stream 1..8 back-to-back; each emerges 5 cycles after acceptance
    for (int i = 0; i < 14; i++) begin
      tick();
      bus.in_valid = (i < 8);
      bus.in_data  = BW'(i + 1);
      #1;
      if (i < 8) chk("stream_pipe_in", 64'(pipe_in), 64'(i + 1));
      chk("stream_out_valid", 64'(out_valid), 64'((i >= 5) && (i <= 12)));
      if (i >= 5 && i <= 12) chk("stream_out_data", 64'(out_data), 64'(i - 4));
    end

    // Preload from idle
    fill_words(10'h200, 37);
    tick(); bus.load_start = 1'b1; #1;
    chk("idle_ls_in_ready", 64'(bus.in_ready), 64'(0));
    chk("idle_ls_busy",     64'(busy),         64'(0));
    tick(); bus.load_start = 1'b0; #1;
    chk("idle_drain_busy",       64'(busy),           64'(1));
    chk("idle_drain_load_ready", 64'(bus.load_ready), 64'(0));
    tick(); #1;
    chk("idle_load_ready", 64'(bus.load_ready), 64'(1));
    for (int k = 0; k < N; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = wa[k];
      #1;
      chk("idle_load_no_set", 64'(set), 64'(0));
      tick();
    end
    bus.load_valid = 1'b0; #1;
    chk("idle_commit_set",        64'(set),           64'(1));
    chk("idle_commit_set_data",   64'(set_data),      64'(exp_sd));
    chk("idle_commit_load_ready", 64'(bus.load_ready), 64'(0));
    chk("idle_commit_in_ready",   64'(bus.in_ready),  64'(0));
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("idle_out_valid", 64'(out_valid), 64'(i < 5));
      if (i < 5) chk("idle_out_data", 64'(out_data), 64'(wa[4-i]));
      chk("idle_after_set", 64'(set),  64'(0));
      chk("idle_after_busy", 64'(busy), 64'(0));
    end

    // Preload with 3 words in flight; load_start beats a same-cycle in_valid
    for (int j = 0; j < 3; j++) begin
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = BW'(50 + j);
    end
    tick();
    bus.load_start = 1'b1;
    bus.in_data    = BW'(99);
    #1;
    chk("ls_beats_in_ready", 64'(bus.in_ready), 64'(0));
    chk("ls_beats_pipe_in",  64'(pipe_in),      64'(0));
    tick(); bus.load_start = 1'b0; #1;
    chk("ls_next_busy",     64'(busy),         64'(1));
    chk("drain_in_ready",   64'(bus.in_ready), 64'(0));
    for (int c = 5; c <= 8; c++) begin
      tick(); #1;
      chk("drain_load_ready", 64'(bus.load_ready), 64'(0));
      chk("drain_in_ready",   64'(bus.in_ready),   64'(0));
      chk("drain_out_valid",  64'(out_valid),      64'(c <= 7));
      if (c <= 7) chk("drain_out_data", 64'(out_data), 64'(50 + c - 5));
    end
    tick(); bus.in_valid = 1'b0; #1;
    chk("drain_to_load", 64'(bus.load_ready), 64'(1));
    fill_words(10'h0A5, 61);
    for (int k = 0; k < N; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = wa[k];
      #1;
      chk("gap_load_no_set", 64'(set), 64'(0));
      tick();
      if (k < N - 1) begin
        for (int g = 0; g < 2; g++) begin
          bus.load_valid = 1'b0; #1;
          chk("gap_idle_no_set",     64'(set),            64'(0));
          chk("gap_idle_load_ready", 64'(bus.load_ready), 64'(1));
          tick();
        end
      end
    end
    bus.load_valid = 1'b0; #1;
    chk("gap_commit_set",      64'(set),      64'(1));
    chk("gap_commit_set_data", 64'(set_data), 64'(exp_sd));
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("gap_out_valid", 64'(out_valid), 64'(i < 5));
      if (i < 5) chk("gap_out_data", 64'(out_data), 64'(wa[4-i]));
      chk("gap_after_set", 64'(set), 64'(0));
    end

    // Flush in LOAD after 2 words, then a fresh preload must need all 5 words
    enter_load();
    for (int k = 0; k < 2; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = BW'(10'h3F0 + k);
      #1;
      tick();
    end
    bus.load_valid = 1'b0;
    bus.flush      = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
    chk("flush_set",      64'(set),          64'(0));
    tick(); bus.flush = 1'b0; #1;
    chk("flush_busy",      64'(busy),         64'(0));
    chk("flush_in_ready1", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_no_set",    64'(set),       64'(0));
      tick(); #1;
    end
    fill_words(10'h111, 83);
    enter_load();
    for (int k = 0; k < N; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = wa[k];
      #1;
      chk("restart_no_early_set", 64'(set), 64'(0));
      tick();
    end
    bus.load_valid = 1'b0; #1;
    chk("restart_commit_set",      64'(set),      64'(1));
    chk("restart_commit_set_data", 64'(set_data), 64'(exp_sd));
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("restart_out_valid", 64'(out_valid), 64'(i < 5));
      if (i < 5) chk("restart_out_data", 64'(out_data), 64'(wa[4-i]));
    end

    // Reset asserted during the COMMIT cycle
    fill_words(10'h2C3, 19);
    enter_load();
    for (int k = 0; k < N; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = wa[k];
      #1;
      tick();
    end
    bus.load_valid = 1'b0;
    reset_n        = 1'b0;
    #1;
    chk("rstc_set", 64'(set), 64'(0));
    tick(); reset_n = 1'b1; #1;
    chk("rstc_in_ready",   64'(bus.in_ready),   64'(1));
    chk("rstc_load_ready", 64'(bus.load_ready), 64'(0));
    chk("rstc_busy",       64'(busy),           64'(0));
    chk("rstc_set_data",   64'(set_data),       64'(0));
    chk("rstc_pipe_in",    64'(pipe_in),        64'(0));
    for (int i = 0; i < 6; i++) begin
      chk("rstc_out_valid", 64'(out_valid), 64'(0));
      chk("rstc_set_idle",  64'(set),       64'(0));
      tick(); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
